// File: rtl/sad_engine_param.sv
// Purpose : sum-of-absolute-differences over an N_PIX block, LANES pixel pairs per beat,
//           with a running minimum SAD / candidate-index tracker for motion search.
// Latency : go sampled at edge 0, first beat accepted at edge 2, done one cycle after last accept.
// Backpr. : in_ready only in ACCUM; in_valid low stalls the block indefinitely without state change.
//
// Ports:
//   clk, Mrst_n        rising-edge clock, asynchronous active-low reset
//   go                 start one block (sampled only in IDLE)
//   clr_min            synchronous clear of min tracker and candidate index (wins over an update)
//   a_data, b_data     LANES packed pixels, lane i at [i*PIX_W +: PIX_W]
//   in_valid/in_ready  beat handshake
//   busy, done         not-IDLE flag, one-cycle completion pulse
//   sad                SAD of last completed block
//   min_sad/min_idx    smallest SAD since clear and its candidate index; min_valid qualifies them

module sad_engine_param #(
    parameter int PIX_W = 8,
    parameter int N_PIX = 16,                  // must be an integer multiple of LANES
    parameter int LANES = 4,
    parameter int IDX_W = 6,
    localparam int BEATS = N_PIX / LANES,
    localparam int SAD_W = PIX_W + $clog2(N_PIX)
) (
    input  logic                     clk,
    input  logic                     Mrst_n,
    input  logic                     go,
    input  logic                     clr_min,
    input  logic [LANES*PIX_W-1:0]   a_data,
    input  logic [LANES*PIX_W-1:0]   b_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic                     busy,
    output logic                     done,
    output logic [SAD_W-1:0]         sad,
    output logic [SAD_W-1:0]         min_sad,
    output logic [IDX_W-1:0]         min_idx,
    output logic                     min_valid
);

    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CLEAR = 2'd1,
        S_ACCUM = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [CNT_W-1:0]   beat_cnt;
    logic [SAD_W-1:0]   acc;
    logic [SAD_W-1:0]   beat_sum;
    logic [SAD_W-1:0]   new_sad;
    logic [IDX_W-1:0]   cand_idx;
    logic               accept;
    logic               last_beat;

    function automatic logic [PIX_W-1:0] abs_diff(input logic [PIX_W-1:0] x,
                                                  input logic [PIX_W-1:0] y);
        return (x >= y) ? (x - y) : (y - x);
    endfunction

    // Per-beat lane sum at full SAD width; SAD_W already covers a whole
    // block of maximal differences, so one beat can never overflow it.
    always_comb begin
        beat_sum = '0;
        for (int i = 0; i < LANES; i++) begin
            beat_sum = beat_sum + SAD_W'(abs_diff(a_data[i*PIX_W +: PIX_W],
                                                  b_data[i*PIX_W +: PIX_W]));
        end
    end

    assign accept    = in_valid && (state == S_ACCUM);
    assign last_beat = accept && (beat_cnt == LAST_BEAT);
    assign new_sad   = acc + beat_sum;

    always_ff @(posedge clk or negedge Mrst_n) begin
        if (!Mrst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        unique case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (go) begin
                    state_nxt = S_CLEAR;
                end
            end
            S_CLEAR: begin
                state_nxt = S_ACCUM;
            end
            S_ACCUM: begin
                in_ready = 1'b1;
                if (last_beat) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Accumulator and beat counter.
    always_ff @(posedge clk or negedge Mrst_n) begin
        if (!Mrst_n) begin
            acc      <= '0;
            beat_cnt <= '0;
            sad      <= '0;
        end else begin
            if (state == S_CLEAR) begin
                acc      <= '0;
                beat_cnt <= '0;
            end else if (accept) begin
                acc      <= new_sad;
                beat_cnt <= beat_cnt + CNT_W'(1);
                if (last_beat) begin
                    sad <= new_sad;
                end
            end
        end
    end

    // Minimum tracker. clr_min takes priority over a coincident last beat,
    // so that block is dropped from the search and indexing restarts at 0.
    // Strict less-than keeps the earlier candidate on ties.
    always_ff @(posedge clk or negedge Mrst_n) begin
        if (!Mrst_n) begin
            min_sad   <= '0;
            min_idx   <= '0;
            min_valid <= 1'b0;
            cand_idx  <= '0;
        end else if (clr_min) begin
            min_sad   <= '0;
            min_idx   <= '0;
            min_valid <= 1'b0;
            cand_idx  <= '0;
        end else if (last_beat) begin
            if (!min_valid || (new_sad < min_sad)) begin
                min_sad   <= new_sad;
                min_idx   <= cand_idx;
                min_valid <= 1'b1;
            end
            cand_idx <= cand_idx + IDX_W'(1);
        end
    end

endmodule

// File: doc/sad_engine_param.md
Name: sad_engine_param

Overview:
- Parametrised sum-of-absolute-differences (SAD) engine for the SAD datapath.
- Integrates the controller FSM and the accumulator in one block.
- Takes LANES pixel pairs per beat over a valid/ready stream and produces the SAD of an N_PIX-pixel block.
- Tracks the minimum SAD and its candidate index across consecutive blocks, for block-matching motion search.

Parameters:
- PIX_W, 8: pixel width in bits (unsigned).
- N_PIX, 16: pixels per block. Must be an integer multiple of LANES.
- LANES, 4: pixel pairs consumed per accepted beat.
- IDX_W, 6: candidate index width.
- Derived, not overridable:
  - BEATS = N_PIX/LANES.
  - SAD_W = PIX_W + clog2(N_PIX).

Ports:
- clk  in  1  rising-edge clock.
- Mrst_n  in  1  reset, asynchronous, active-low.
- go  in  1  start one block. Sampled only in IDLE.
- clr_min  in  1  synchronous clear of the min tracker and candidate index.
- a_data  in  LANES*PIX_W  current-block pixels. Lane i is at bits [i*PIX_W +: PIX_W].
- b_data  in  LANES*PIX_W  reference-block pixels, same packing.
- in_valid  in  1  a_data/b_data valid.
- in_ready  out  1  engine accepts a beat.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse: sad is updated.
- sad  out  SAD_W  SAD of the last completed block.
- min_sad  out  SAD_W  smallest SAD since the last clear.
- min_idx  out  IDX_W  candidate index of min_sad.
- min_valid  out  1  min_sad/min_idx hold a recorded value.

Behaviour:
- Reset (Mrst_n=0, async):
  - State goes to IDLE; beat counter, accumulator, sad, min_sad, min_idx, cand_idx and min_valid all go to 0.
  - in_ready=0, busy=0, done=0.
  - Reset mid-block abandons the block with no done pulse.
- States: IDLE, CLEAR, ACCUM, DONE.
- IDLE:
  - in_ready=0.
  - go=1 -> CLEAR.
  - go in any other state is ignored.
- CLEAR:
  - Single cycle: acc<=0, beat_cnt<=0, then -> ACCUM.
  - in_ready=0.
- ACCUM:
  - in_ready=1.
  - Beat accepted when in_valid & in_ready. On accept:
    - acc <= acc + sum over lanes of |a_i - b_i|, computed at full width with no truncation.
    - beat_cnt increments.
  - in_valid=0 stalls the block indefinitely with no state change.
  - On accept of beat BEATS-1:
    - sad <= acc + beat_sum.
    - Minimum update and cand_idx increment, below.
    - State -> DONE.
- DONE:
  - done=1 for exactly one cycle, in_ready=0, then -> IDLE.
  - Earliest next go is sampled in IDLE.
  - Block period is BEATS+3 cycles with no stalls.
- Latency: go sampled at edge 0; first beat can be accepted at edge 2; done is high in the cycle after the last accepting edge.
- Minimum tracker, applied on the last-beat edge with new = acc + beat_sum:
  - If !min_valid or new < min_sad (strict): min_sad<=new, min_idx<=cand_idx, min_valid<=1.
  - Ties keep the earlier index.
  - cand_idx<=cand_idx+1, wrapping modulo 2^IDX_W. Wrap does not clear min_valid.
- clr_min=1 on any edge: min_valid<=0, min_sad<=0, min_idx<=0, cand_idx<=0.
  - If coincident with a last-beat edge, clr_min wins: that block's result is not recorded and cand_idx=0 afterwards.
  - sad and done still update normally.
- sad, min_sad and min_idx hold between updates.
- SAD_W is sufficient for an all-max block: N_PIX*(2^PIX_W-1). No saturation logic.

Test Plan:
- Reset then one block, defaults (N_PIX=16, LANES=4), every a=200 and b=50, in_valid held high:
  - 4 beats accepted on consecutive cycles.
  - done pulses one cycle later with sad=2400.
  - min_sad=2400, min_idx=0, min_valid=1.
- Overflow bound: every a=255, b=0 -> sad=4080 with no wrap in the 12-bit output. Swap a/b -> same 4080.
- Three blocks with SADs 500, 300, 300:
  - min_sad=300, min_idx=1 (tie keeps index 1).
  - Next block ends with cand_idx=3.
- Stalls: in_valid toggles 1,0,0,1,1,0,1 -> exactly 4 beats accepted; the done cycle is delayed by the 3 idle cycles; sad is unchanged versus the no-stall run.
- clr_min on the last-beat edge of block 2 -> sad updates, done pulses, min_valid=0, cand_idx=0. The next block records min_idx=0.
- Mrst_n pulsed low mid-ACCUM after 2 beats:
  - All outputs go to 0 immediately, with no done pulse.
  - go during ACCUM is ignored.
  - A fresh block afterwards gives the correct SAD.
